// File: rtl/dmem_responder.sv
// Data-memory responder: single-outstanding load/store slave with a programmable
// wait-state delay between request acceptance and response.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t         state;
  logic [3:0]     cnt;
  logic [31:0]    mem [DEPTH_WORDS];
  logic [29:0]    widx;
  logic [AW-1:0]  idx;
  logic           accept;
  logic           err;

  assign widx   = req_addr[31:2];
  assign idx    = widx[AW-1:0];
  assign accept = req_valid & req_ready;
  assign err    = (req_addr[1:0] != 2'b00) || ({2'b00, widx} >= DEPTH_WORDS);

  // Array has no reset so a store accepted just before reset stays committed.
  always_ff @(posedge clk) begin
    if (accept && req_we && !err) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (req_be[i]) mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (accept) begin
            req_ready <= 1'b0;
            rsp_err   <= err;
            rsp_rdata <= (err || req_we) ? '0 : mem[idx];
            if (LATENCY == 0) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
            end else begin
              state <= WAIT;
              cnt   <= 4'(LATENCY - 1);
            end
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: two instances (LATENCY 2 and 0) checked
// every cycle against a transaction-level memory/timing model.
module tb_dmem_responder;

  localparam int unsigned DW = 64;
  localparam int unsigned L0 = 2;
  localparam int unsigned L1 = 0;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_be    [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DW), .LATENCY(L0)) u_dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  dmem_responder #(.DEPTH_WORDS(DW), .LATENCY(L1)) u_dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  // ---------------- reference model ----------------
  logic [31:0] mem_m  [2][DW];
  bit          busy_m [2] = '{0, 0};
  bit          vld_m  [2] = '{0, 0};
  bit          ready_m[2] = '{0, 0};
  int          due_m  [2] = '{0, 0};
  logic [31:0] data_m [2] = '{0, 0};
  bit          err_m  [2] = '{0, 0};
  int          cyc = 0;

  function automatic int lat_of(input int d);
    return (d == 0) ? int'(L0) : int'(L1);
  endfunction

  // Responder is busy from acceptance until its response is consumed; the
  // response becomes visible LATENCY edges after the acceptance edge.
  initial begin
    logic [31:0] a;
    int          wi;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        for (int d = 0; d < 2; d++) begin
          busy_m[d] = 0; vld_m[d] = 0; ready_m[d] = 0;
        end
      end else begin
        cyc++;
        for (int d = 0; d < 2; d++) begin
          if (vld_m[d] && rsp_ready[d]) begin
            busy_m[d] = 0;
            vld_m[d]  = 0;
          end else if (ready_m[d] && req_valid[d]) begin
            busy_m[d] = 1;
            due_m[d]  = cyc + lat_of(d);
            a = req_addr[d];
            if (a[1:0] != 2'b00 || (a >> 2) >= DW) begin
              err_m[d] = 1; data_m[d] = '0;
            end else begin
              err_m[d] = 0;
              wi = int'(a >> 2);
              if (req_we[d]) begin
                for (int b = 0; b < 4; b++)
                  if (req_be[d][b]) mem_m[d][wi][8*b +: 8] = req_wdata[d][8*b +: 8];
                data_m[d] = '0;
              end else begin
                data_m[d] = mem_m[d][wi];
              end
            end
          end
          if (busy_m[d] && !vld_m[d] && cyc >= due_m[d]) vld_m[d] = 1;
          ready_m[d] = !busy_m[d];
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    failures++;
    $display("FAIL %s: bound expired (t=%0t)", nm, $time);
  endtask

  // Per-cycle compare against the model, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("req_ready[%0d]", d), req_ready[d], ready_m[d]);
        chk($sformatf("rsp_valid[%0d]", d), rsp_valid[d], vld_m[d]);
        if (!rst) begin
          chk($sformatf("rst_rdata[%0d]", d), rsp_rdata[d], 0);
          chk($sformatf("rst_err[%0d]", d), rsp_err[d], 0);
        end else if (vld_m[d]) begin
          chk($sformatf("rsp_rdata[%0d]", d), rsp_rdata[d], data_m[d]);
          chk($sformatf("rsp_err[%0d]", d), rsp_err[d], err_m[d]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input int d, input bit we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] be, output bit ok);
    @(negedge clk);
    req_we[d] = we; req_addr[d] = addr; req_wdata[d] = wdata; req_be[d] = be;
    req_valid[d] = 1'b1;
    ok = 0;
    for (int n = 0; n < 50; n++) begin
      if (req_ready[d]) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      timeout($sformatf("accept[%0d]", d));
      req_valid[d] = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      req_valid[d] = 1'b0;
      req_we[d]    = 1'($urandom_range(0, 1));
      req_addr[d]  = $urandom;
      req_wdata[d] = $urandom;
      req_be[d]    = 4'($urandom_range(0, 15));
    end
  endtask

  task automatic xact(input int d, input bit we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] be, input int hold,
                      output logic [31:0] rd, output logic er, output int lat);
    bit ok, found;
    rsp_ready[d] = 1'b0;
    rd = '0; er = 1'b0; lat = -1;
    send(d, we, addr, wdata, be, ok);
    if (ok) begin
      found = 0;
      for (int n = 1; n <= 40; n++) begin
        @(negedge clk);
        if (rsp_valid[d]) begin found = 1; lat = n; break; end
        rsp_ready[d] = 1'($urandom_range(0, 1));
      end
      if (!found) begin
        timeout($sformatf("response[%0d]", d));
      end else begin
        rd = rsp_rdata[d]; er = rsp_err[d];
        rsp_ready[d] = 1'b0;
        repeat (hold) @(negedge clk);
        rsp_ready[d] = 1'b1;
        @(posedge clk);
        #1 rsp_ready[d] = 1'b0;
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    bit          ok;
    int          acc [6];
    logic [31:0] a;

    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 0; req_we[d] = 0; req_addr[d] = '0; req_wdata[d] = '0;
      req_be[d] = '0; rsp_ready[d] = 0;
    end

    repeat (3) @(negedge clk);
    chk("reset_req_ready", req_ready[0], 0);
    chk("reset_rsp_valid", rsp_valid[0], 0);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("ready_after_release", req_ready[0], 1);

    for (int i = 0; i < int'(DW); i++)
      for (int d = 0; d < 2; d++)
        xact(d, 1, 32'(i * 4), 32'hC0DE0000 | 32'(i), 4'hF, 0, rd, er, lat);

    xact(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, er, lat);
    chk("store_lat", 32'(lat), 3);
    chk("store_rdata", rd, 0);
    chk("store_err", 32'(er), 0);
    xact(0, 0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat);
    chk("load_rdata", rd, 32'hDEADBEEF);
    chk("load_err", 32'(er), 0);

    xact(0, 1, 32'h20, 32'hFFFFFFFF, 4'hF, 0, rd, er, lat);
    xact(0, 1, 32'h20, 32'h00AB0000, 4'h4, 0, rd, er, lat);
    xact(0, 0, 32'h20, 32'h0, 4'hF, 0, rd, er, lat);
    chk("partial_rdata", rd, 32'hFFABFFFF);
    xact(0, 1, 32'h20, 32'h12121212, 4'h0, 0, rd, er, lat);
    chk("be0_err", 32'(er), 0);
    xact(0, 0, 32'h20, 32'h0, 4'h0, 0, rd, er, lat);
    chk("be0_rdata", rd, 32'hFFABFFFF);

    xact(0, 0, 32'h13, 32'h0, 4'hF, 0, rd, er, lat);
    chk("misalign_err", 32'(er), 1);
    chk("misalign_rdata", rd, 0);
    xact(0, 1, 32'(DW * 4), 32'h55555555, 4'hF, 0, rd, er, lat);
    chk("oob_err", 32'(er), 1);
    xact(0, 0, 32'h0, 32'h0, 4'hF, 0, rd, er, lat);
    chk("oob_nowrite", rd, 32'hC0DE0000);

    xact(0, 0, 32'h10, 32'h0, 4'hF, 5, rd, er, lat);
    chk("bp_rdata", rd, 32'hDEADBEEF);
    @(negedge clk);
    chk("bp_ready_back", req_ready[0], 1);

    rsp_ready[1] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      a = 32'($urandom_range(0, DW - 1) * 4);
      send(1, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), ok);
      acc[k] = cyc;
      if (k > 0) chk($sformatf("b2b_gap%0d", k), 32'(acc[k] - acc[k-1]), 2);
    end
    @(posedge clk);
    #1 rsp_ready[1] = 1'b0;
    xact(1, 1, 32'h44, 32'hA1B2C3D4, 4'hF, 0, rd, er, lat);
    chk("lat0_lat", 32'(lat), 1);
    xact(1, 0, 32'h44, 32'h0, 4'hF, 0, rd, er, lat);
    chk("lat0_rdata", rd, 32'hA1B2C3D4);

    send(0, 1, 32'h30, 32'h12345678, 4'hF, ok);
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_wait_valid", rsp_valid[0], 0);
    chk("rst_wait_ready", req_ready[0], 0);
    #2 rst = 1'b1;
    xact(0, 0, 32'h30, 32'h0, 4'hF, 0, rd, er, lat);
    chk("rst_wait_commit", rd, 32'h12345678);
    chk("rst_wait_lat", 32'(lat), 3);

    for (int i = 0; i < 80; i++) begin
      int d;
      int r;
      d = $urandom_range(0, 1);
      r = $urandom_range(0, 9);
      if (r == 0)      a = $urandom | 32'h0001_0000;
      else if (r == 1) a = 32'($urandom_range(0, DW - 1) * 4 + $urandom_range(1, 3));
      else             a = 32'($urandom_range(0, DW - 1) * 4);
      xact(d, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
           $urandom_range(0, 3), rd, er, lat);
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
